// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding and the R/W bit values used on the bus.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StStop
    } i2c_state_e;

    localparam logic RwWrite = 1'b0;
    localparam logic RwRead  = 1'b1;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-cell tick generator; the count freezes while stall_i is high and clears while disabled.
module i2c_clk_div #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic stall_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (!stall_i) begin
            if (cnt_q == CntMax) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_controller.sv
// Single-byte I2C master: START, address+R/W, one data byte written or read, STOP.
// Open-drain SCL/SDA, four quarters per bit cell, SCL stretching honoured in Q1.
module i2c_controller
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata,
    inout  wire        scl,
    inout  wire        sda
);

    i2c_state_e state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic       done_q, done_d;
    logic       scl_low_q, scl_low_d;
    logic       sda_low_q, sda_low_d;
    logic       scl_meta_q, scl_sync_q;
    logic       sda_meta_q, sda_sync_q;
    logic       tick;
    logic       stall;
    logic       accept;

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign nack   = nack_q;
    assign rdata  = rdata_q;
    assign scl    = scl_low_q ? 1'b0 : 1'bz;
    assign sda    = sda_low_q ? 1'b0 : 1'bz;

    // A request landing in the done cycle is dropped, not started.
    assign accept = (state_q == StIdle) && req && !done_q;
    // Q1 waits for SCL to actually read high so a peripheral can stretch the clock.
    assign stall  = (qtr_q == 2'd1) && !scl_sync_q;

    i2c_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (busy),
        .stall_i(stall),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = StStart;
            qtr_d   = 2'd0;
            bit_d   = 3'd0;
            sh_d    = {addr, rw};
            wdata_d = wdata;
            rw_d    = rw;
            nack_d  = 1'b0;
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd1) begin
                case (state_q)
                    StAddrAck, StWriteAck: nack_d = nack_q | sda_sync_q;
                    StRead:                sh_d   = {sh_q[6:0], sda_sync_q};
                    default:               ;
                endcase
            end else if (qtr_q == 2'd3) begin
                case (state_q)
                    StStart: state_d = StAddr;
                    StAddr: begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd7) state_d = StAddrAck;
                    end
                    StAddrAck: begin
                        if (nack_q) begin
                            state_d = StStop;
                        end else if (rw_q == RwRead) begin
                            state_d = StRead;
                        end else begin
                            state_d = StWrite;
                            sh_d    = wdata_q;
                        end
                    end
                    StWrite: begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd7) state_d = StWriteAck;
                    end
                    StRead: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StReadAck;
                    end
                    StWriteAck, StReadAck: state_d = StStop;
                    StStop: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        if ((rw_q == RwRead) && !nack_q) rdata_d = sh_q;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Line drive follows the next state so pins change on the same edge as the quarter.
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            StIdle: ;
            StStart: begin
                sda_low_d = 1'b1;
                scl_low_d = (qtr_d == 2'd3);
            end
            StAddr, StWrite: begin
                sda_low_d = !sh_d[7];
                scl_low_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
            end
            StStop: begin
                sda_low_d = (qtr_d <= 2'd1);
                scl_low_d = (qtr_d == 2'd0);
            end
            default: scl_low_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            sh_q       <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
        end
    end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with a behavioural peripheral at address 0x42 on the bus.
module tb_i2c_controller;

    localparam int Div  = 8;
    localparam int Cell = 4 * Div + 2;
    localparam logic [6:0] PerAddr = 7'h42;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, nack;
    logic [7:0] rdata;
    wire        scl, sda;
    logic       tb_scl_low = 1'b0;
    logic       per_sda_low = 1'b0;
    logic [7:0] per_tx = 8'h00;
    logic [7:0] per_rx = 8'h00;

    assign scl = tb_scl_low ? 1'b0 : 1'bz;
    assign sda = per_sda_low ? 1'b0 : 1'bz;
    pullup (scl);
    pullup (sda);

    i2c_controller #(
        .CLK_DIV(Div)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .addr   (addr),
        .rw     (rw),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .nack   (nack),
        .rdata  (rdata),
        .scl    (scl),
        .sda    (sda)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int done_cnt = 0;
    logic [7:0] bytes_q[$];
    logic       acks_q[$];
    int         falls_q[$];

    typedef enum {PhIdle, PhAddr, PhWr, PhRd, PhIgn} ph_e;
    ph_e ph = PhIdle;
    int  slot = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor and peripheral: samples on negedge, drives SDA only while SCL is low.
    initial begin
        logic pscl, psda, match, prd;
        logic [7:0] psh;
        pscl = 1'b1; psda = 1'b1; match = 1'b0; prd = 1'b0; psh = 8'h00;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (pscl && scl && psda && !sda) begin
                start_cnt++;
                ph = PhAddr;
                slot = -1;
                per_sda_low = 1'b0;
            end else if (pscl && scl && !psda && sda) begin
                stop_cnt++;
                ph = PhIdle;
                per_sda_low = 1'b0;
            end else if (!pscl && scl) begin
                if (ph != PhIdle && ph != PhIgn && slot >= 0) begin
                    if (slot < 8) begin
                        psh = {psh[6:0], sda};
                        if (slot == 7) bytes_q.push_back(psh);
                    end else begin
                        acks_q.push_back(sda);
                    end
                end
            end else if (pscl && !scl) begin
                falls_q.push_back(cyc);
                if (ph != PhIdle && ph != PhIgn) begin
                    slot++;
                    per_sda_low = 1'b0;
                    if (slot == 9) begin
                        slot = 0;
                        if (ph == PhAddr) ph = !match ? PhIgn : (prd ? PhRd : PhWr);
                        else if (ph == PhRd) ph = PhIgn;
                    end
                    if (slot == 8) begin
                        if (ph == PhAddr) begin
                            match = (psh[7:1] == PerAddr);
                            prd = psh[0];
                            per_sda_low = match;
                        end else if (ph == PhWr) begin
                            per_rx = psh;
                            per_sda_low = 1'b1;
                        end
                    end else if (ph == PhRd) begin
                        per_sda_low = !per_tx[3'(7 - slot)];
                    end
                end
            end
            pscl = scl;
            psda = sda;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_req(input logic [6:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        addr = a; rw = r; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int b0, a0, s0, p0, d0, f0, fcyc;
        bit ok;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_nack", 32'(nack), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'h00);
        check_eq("rst_scl", 32'(scl), 32'd1);
        check_eq("rst_sda", 32'(sda), 32'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write 0xA5 to 0x42
        b0 = bytes_q.size(); a0 = acks_q.size(); s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
        pulse_req(7'h42, 1'b0, 8'hA5);
        check_eq("wr_busy", 32'(busy), 32'd1);
        wait_done("wr_done_seen");
        check_eq("wr_nack", 32'(nack), 32'd0);
        check_eq("wr_nbytes", 32'(bytes_q.size() - b0), 32'd2);
        check_eq("wr_addr_byte", 32'(bytes_q[b0]), 32'h84);
        check_eq("wr_addr_ack", 32'(acks_q[a0]), 32'd0);
        check_eq("wr_data_byte", 32'(bytes_q[b0 + 1]), 32'hA5);
        check_eq("wr_data_ack", 32'(acks_q[a0 + 1]), 32'd0);
        check_eq("wr_per_rx", 32'(per_rx), 32'hA5);
        @(negedge clk);
        check_eq("wr_done_pulse", 32'(done), 32'd0);
        check_eq("wr_idle", 32'(busy), 32'd0);
        check_eq("wr_starts", 32'(start_cnt - s0), 32'd1);
        check_eq("wr_stops", 32'(stop_cnt - p0), 32'd1);
        check_eq("wr_dones", 32'(done_cnt - d0), 32'd1);

        // Clock stretch: hold SCL low 50 clocks past the release in the third address cell
        b0 = bytes_q.size(); f0 = falls_q.size();
        pulse_req(7'h42, 1'b0, 8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (falls_q.size() >= f0 + 3) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("st_fall_seen", 32'(ok), 32'd1);
        fcyc = falls_q[f0 + 2];
        tb_scl_low = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (cyc >= fcyc + 2 * Div + 50) break;
        end
        tb_scl_low = 1'b0;
        wait_done("st_done_seen");
        check_eq("st_cell_normal", 32'(falls_q[f0 + 2] - falls_q[f0 + 1]), 32'(Cell));
        check_eq("st_cell_stretch", 32'(falls_q[f0 + 3] - falls_q[f0 + 2]), 32'(Cell + 50));
        check_eq("st_cell_after", 32'(falls_q[f0 + 4] - falls_q[f0 + 3]), 32'(Cell));
        check_eq("st_addr_byte", 32'(bytes_q[b0]), 32'h84);
        check_eq("st_per_rx", 32'(per_rx), 32'h5A);
        check_eq("st_nack", 32'(nack), 32'd0);

        // Read 0x3C from 0x42
        per_tx = 8'h3C;
        repeat (5) @(negedge clk);
        b0 = bytes_q.size(); a0 = acks_q.size();
        pulse_req(7'h42, 1'b1, 8'h00);
        wait_done("rd_done_seen");
        check_eq("rd_rdata", 32'(rdata), 32'h3C);
        check_eq("rd_nack", 32'(nack), 32'd0);
        check_eq("rd_addr_byte", 32'(bytes_q[b0]), 32'h85);
        check_eq("rd_addr_ack", 32'(acks_q[a0]), 32'd0);
        check_eq("rd_data_byte", 32'(bytes_q[b0 + 1]), 32'h3C);
        check_eq("rd_master_nack", 32'(acks_q[a0 + 1]), 32'd1);

        // No responder at 0x10
        repeat (5) @(negedge clk);
        b0 = bytes_q.size(); a0 = acks_q.size(); p0 = stop_cnt;
        pulse_req(7'h10, 1'b0, 8'h99);
        wait_done("nk_done_seen");
        check_eq("nk_nack", 32'(nack), 32'd1);
        check_eq("nk_rdata_kept", 32'(rdata), 32'h3C);
        check_eq("nk_nbytes", 32'(bytes_q.size() - b0), 32'd1);
        check_eq("nk_addr_byte", 32'(bytes_q[b0]), 32'h20);
        check_eq("nk_addr_ack", 32'(acks_q[a0]), 32'd1);
        check_eq("nk_stops", 32'(stop_cnt - p0), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("nk_nack_held", 32'(nack), 32'd1);

        // Requests while busy and in the done cycle are dropped
        b0 = bytes_q.size(); s0 = start_cnt; d0 = done_cnt;
        pulse_req(7'h42, 1'b0, 8'h11);
        check_eq("bz_nack_clr", 32'(nack), 32'd0);
        check_eq("bz_busy", 32'(busy), 32'd1);
        repeat (40) @(negedge clk);
        pulse_req(7'h10, 1'b0, 8'hEE);
        wait_done("bz_done_seen");
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_eq("bz_done_req_ignored", 32'(busy), 32'd0);
        repeat (50) @(negedge clk);
        check_eq("bz_starts", 32'(start_cnt - s0), 32'd1);
        check_eq("bz_dones", 32'(done_cnt - d0), 32'd1);
        check_eq("bz_addr_byte", 32'(bytes_q[b0]), 32'h84);
        check_eq("bz_per_rx", 32'(per_rx), 32'h11);
        check_eq("bz_idle", 32'(busy), 32'd0);

        // Reset in the middle of the write data byte
        pulse_req(7'h42, 1'b0, 8'hC3);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ph == PhWr && slot == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("mr_reached_write", 32'(ok), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mr_scl", 32'(scl), 32'd1);
        check_eq("mr_sda", 32'(sda), 32'd1);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_rdata", 32'(rdata), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        b0 = bytes_q.size(); s0 = start_cnt;
        pulse_req(7'h42, 1'b0, 8'h77);
        wait_done("mr_done_seen");
        check_eq("mr_nack", 32'(nack), 32'd0);
        check_eq("mr_addr_byte", 32'(bytes_q[b0]), 32'h84);
        check_eq("mr_data_byte", 32'(bytes_q[b0 + 1]), 32'h77);
        check_eq("mr_per_rx", 32'(per_rx), 32'h77);
        check_eq("mr_starts", 32'(start_cnt - s0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_controller.md
I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 Parameter CLK_DIV, default 25; system clocks per quarter SCL bit-cell (SCL = f_clk/(4*CLK_DIV)).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req  input  1  transaction request; sampled only when busy=0.
REQ-005 addr  input  7  target peripheral address, captured with req.
REQ-006 rw  input  1  0 = write byte to peripheral, 1 = read byte from peripheral (the R/W bit sent on the bus).
REQ-007 wdata  input  8  write byte, captured with req.
REQ-008 busy  output  1  high from the cycle after an accepted req until done.
REQ-009 done  output  1  one-cycle pulse at the end of the transaction.
REQ-010 nack  output  1  valid with done: 1 = address or write-data NACK; held until next accepted req.
REQ-011 rdata  output  8  byte read; updated only on done of a successful read.
REQ-012 scl  inout  1  open-drain: driven 0 or released to Z, never driven 1.
REQ-013 sda  inout  1  open-drain: driven 0 or released to Z, never driven 1.

Function
REQ-014 A quarter tick fires every CLK_DIV clocks while busy; the divider counter is held at 0 while idle.
REQ-015 Bit cell = quarters Q0..Q3: SDA updated at Q0 start, SCL released at Q1 start, SDA sampled at Q2 start, SCL pulled low at Q3 start.
REQ-016 Clock stretching: in Q1, the quarter counter stalls until scl reads 1; the stall has no timeout.
REQ-017 States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
REQ-018 IDLE: both lines released; req=1 captures addr/rw/wdata, clears nack, enters START.
REQ-019 START: with SCL released, SDA pulled low for one full cell, then SCL pulled low; go to ADDR.
REQ-020 ADDR: shift {addr, rw} MSB first, 8 cells; then ADDR_ACK.
REQ-021 ADDR_ACK: SDA released; sampled 0 -> WRITE if rw=0 else READ; sampled 1 -> nack=1, STOP.
REQ-022 WRITE: shift wdata MSB first, 8 cells; WRITE_ACK samples SDA, 1 sets nack; always -> STOP.
REQ-023 READ: SDA released, 8 samples shifted in MSB first; READ_ACK: controller releases SDA (NACK, single-byte read) -> STOP.
REQ-024 STOP: SDA pulled low at Q0, SCL released at Q1, SDA released at Q2; at Q3 end assert done, return to IDLE.
REQ-025 Bit counter is 3 bits, wraps 7->0 at each byte-to-ACK transition.
REQ-026 req while busy=1 is ignored, not queued; req in the done cycle is ignored.
REQ-027 rdata loads the shift register in the done cycle only when rw=1 and nack=0.
REQ-028 scl and sda inputs pass through a two-flop synchronizer before use.

Reset
REQ-029 reset_n low: state IDLE, both lines released immediately, busy=0, done=0, nack=0, rdata=0x00, counters 0.
REQ-030 Reset mid-transaction aborts without generating STOP; the next req starts with a fresh START.

Structure
REQ-031 Shared package i2c_pkg holds the state enum and the R/W bit encoding, shared with i2c_peripheral.
REQ-032 One sub-module, i2c_clk_div, generates the quarter tick with a stall input.

Verification
REQ-033 Write addr=0x42, wdata=0xA5, i2c_peripheral(0x42) on bus -> bus shows START, 0x84, ACK, 0xA5, ACK, STOP; done with nack=0; peripheral rx=0xA5.
REQ-034 Read addr=0x42, peripheral tx=0x3C -> bus shows 0x85, ACK, 0x3C, controller NACK, STOP; rdata=0x3C, nack=0.
REQ-035 Write addr=0x10 with no responder -> ADDR_ACK samples 1, STOP issued, done with nack=1, rdata unchanged.
REQ-036 Bench holds scl low 50 clocks in a Q1 -> cell stretched by exactly 50 clocks, data unchanged.
REQ-037 Second req pulsed while busy -> exactly one transaction on the bus, one done.
REQ-038 reset_n low mid-WRITE -> scl and sda read Z in the same cycle, busy=0; next req completes normally.
